// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for the parametrised 1RW SRAM model.
//   sram_state_t : clear-sweep FSM states (SRAM_CLEAR, SRAM_READY)
//   num_wmasks   : number of write-mask lanes for a given geometry
//   lane_parity  : even parity of one (zero-extended) write lane
package sram_pkg;

    typedef enum logic {
        SRAM_CLEAR = 1'b0,
        SRAM_READY = 1'b1
    } sram_state_t;

    // Widest lane lane_parity accepts; narrower lanes are zero-extended,
    // which does not change their parity.
    localparam int unsigned SRAM_MAX_LANE = 256;

    function automatic int unsigned num_wmasks(input int unsigned data_width,
                                               input int unsigned write_size);
        return data_width / write_size;
    endfunction

    function automatic logic lane_parity(input logic [SRAM_MAX_LANE-1:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// sram_clear_fsm: post-reset zero-clear sequencer for the SRAM array.
//   clk0       in   clock
//   rst0       in   asynchronous reset, active-high
//   clear_we   out  array write strobe for the sweep (high in SRAM_CLEAR)
//   clear_addr out  sweep address (counter)
//   ready0     out  registered "array accepts requests" flag
// With CLEAR_ON_RESET=0 the FSM comes out of reset already in SRAM_READY.
module sram_clear_fsm
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  ready0
);

    localparam sram_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? SRAM_CLEAR : SRAM_READY;

    sram_state_t           state, state_next;
    logic [ADDR_WIDTH-1:0] cnt, cnt_next;

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state  <= RESET_STATE;
            cnt    <= '0;
            ready0 <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            ready0 <= (state_next == SRAM_READY);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clear_we   = 1'b0;
        clear_addr = cnt;
        case (state)
            SRAM_CLEAR: begin
                clear_we = 1'b1;
                cnt_next = cnt + ADDR_WIDTH'(1);
                // Last address written this edge; cnt wraps back to 0.
                if (cnt == '1) begin
                    state_next = SRAM_READY;
                end
            end
            SRAM_READY: begin
                state_next = SRAM_READY;
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

endmodule

// File: rtl/sram_1rw_param.sv
// sram_1rw_param: parametrised single-port (1RW) synchronous SRAM model.
//   clk0   in   clock
//   rst0   in   asynchronous reset, active-high (control registers only)
//   csb0   in   chip select, active-low
//   web0   in   write enable, active-low
//   wmask0 in   per-lane write mask (NUM_WMASKS bits)
//   addr0  in   address
//   din0   in   write data
//   dout0  out  read data, combinational from the captured address
//   perr0  out  per-lane parity error (only with SRAM_PARITY_EN defined)
//   ready0 out  high when the array accepts requests
// Inputs are captured on the clock edge; a captured write commits on the
// next edge. Define SRAM_PARITY_EN to add per-lane even-parity storage.
module sram_1rw_param
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned WRITE_SIZE     = 8,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter int unsigned WRITE_FIRST    = 0,
    localparam int unsigned NUM_WMASKS    = num_wmasks(DATA_WIDTH, WRITE_SIZE)
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
`ifdef SRAM_PARITY_EN
    output logic [NUM_WMASKS-1:0] perr0,
`endif
    output logic                  ready0
);

    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  web0_reg;
    logic [NUM_WMASKS-1:0] wmask0_reg;
    logic [ADDR_WIDTH-1:0] addr0_reg;
    logic [DATA_WIDTH-1:0] din0_reg;

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;

    logic [DATA_WIDTH-1:0] rd_word, merged_word, wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_en;

    sram_clear_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_fsm (
        .clk0       (clk0),
        .rst0       (rst0),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .ready0     (ready0)
    );

    // Input capture is suppressed for the whole sweep; csb0 is ignored.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            web0_reg   <= 1'b1;
            wmask0_reg <= '0;
            addr0_reg  <= '0;
            din0_reg   <= '0;
        end else if (!clear_we && !csb0) begin
            web0_reg   <= web0;
            wmask0_reg <= wmask0;
            addr0_reg  <= addr0;
            din0_reg   <= din0;
        end
    end

    assign rd_word = mem[addr0_reg];

    // Masked write done as a whole-word read-modify-write so the sweep and
    // user writes share one array write port.
    always_comb begin
        merged_word = rd_word;
        for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0_reg[i]) begin
                merged_word[i*WRITE_SIZE +: WRITE_SIZE] = din0_reg[i*WRITE_SIZE +: WRITE_SIZE];
            end
        end
    end

    assign wr_en   = !rst0 && (clear_we || !web0_reg);
    assign wr_addr = clear_we ? clear_addr : addr0_reg;
    assign wr_data = clear_we ? '0 : merged_word;

    always_ff @(posedge clk0) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ready0 is low through reset and the sweep, which forces dout0 to 0.
    always_comb begin
        dout0 = '0;
        if (ready0) begin
            dout0 = ((WRITE_FIRST != 0) && !web0_reg) ? merged_word : rd_word;
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NUM_WMASKS-1:0] par_mem [RAM_DEPTH];
    logic [NUM_WMASKS-1:0] rd_par, wr_par;

    assign rd_par = par_mem[addr0_reg];

    always_comb begin
        wr_par = rd_par;
        for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0_reg[i]) begin
                wr_par[i] = lane_parity(SRAM_MAX_LANE'(din0_reg[i*WRITE_SIZE +: WRITE_SIZE]));
            end
        end
        if (clear_we) begin
            wr_par = '0;
        end
    end

    always_ff @(posedge clk0) begin
        if (wr_en) begin
            par_mem[wr_addr] <= wr_par;
        end
    end

    always_comb begin
        perr0 = '0;
        if (ready0) begin
            for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
                perr0[i] = lane_parity(SRAM_MAX_LANE'(rd_word[i*WRITE_SIZE +: WRITE_SIZE])) ^ rd_par[i];
            end
        end
    end

    // Error-injection hook: flips one stored data bit, leaving parity as is.
    task automatic flip_bit(input logic [ADDR_WIDTH-1:0] addr, input int unsigned bit_idx);
        mem[addr][bit_idx] = ~mem[addr][bit_idx];
    endtask
`endif

endmodule

// File: tb/tb_sram_1rw_param.sv
module tb_sram_1rw_param;

`ifdef SRAM_PARITY_EN
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 6;
    localparam int unsigned WS = 16;
`else
    localparam int unsigned DW = 256;
    localparam int unsigned AW = 4;
    localparam int unsigned WS = 8;
`endif
    localparam int unsigned NW    = DW / WS;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk0 = 1'b0;
    logic          rst0, csb0, web0;
    logic [NW-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout_rf, dout_wf;
    logic          ready_rf, ready_wf;
`ifdef SRAM_PARITY_EN
    logic [NW-1:0] perr_rf, perr_wf;
`endif

    int unsigned   vectors     = 0;
    int unsigned   miscompares = 0;
    logic [DW-1:0] model [DEPTH];
    logic [AW-1:0] cur_addr;

    always #5 clk0 = ~clk0;

    sram_1rw_param #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .WRITE_SIZE (WS),
        .CLEAR_ON_RESET (1), .WRITE_FIRST (0)
    ) dut (
        .clk0 (clk0), .rst0 (rst0), .csb0 (csb0), .web0 (web0),
        .wmask0 (wmask0), .addr0 (addr0), .din0 (din0), .dout0 (dout_rf),
`ifdef SRAM_PARITY_EN
        .perr0 (perr_rf),
`endif
        .ready0 (ready_rf)
    );

    sram_1rw_param #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .WRITE_SIZE (WS),
        .CLEAR_ON_RESET (1), .WRITE_FIRST (1)
    ) dut_wf (
        .clk0 (clk0), .rst0 (rst0), .csb0 (csb0), .web0 (web0),
        .wmask0 (wmask0), .addr0 (addr0), .din0 (din0), .dout0 (dout_wf),
`ifdef SRAM_PARITY_EN
        .perr0 (perr_wf),
`endif
        .ready0 (ready_wf)
    );

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int unsigned i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // Reference lane merge: bit b belongs to lane b/WS.
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [NW-1:0] m);
        logic [DW-1:0] r;
        for (int unsigned b = 0; b < DW; b++) r[b] = m[b / WS] ? n[b] : o[b];
        return r;
    endfunction

    task automatic drive_idle();
        csb0 = 1'b1; web0 = 1'(($urandom() & 1));
        addr0 = AW'($urandom()); din0 = rand_word(); wmask0 = NW'($urandom());
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NW-1:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m; cur_addr = a;
    endtask

    task automatic drive_read(input logic [AW-1:0] a);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a; din0 = rand_word(); wmask0 = NW'($urandom()); cur_addr = a;
    endtask

    task automatic drive_clear_noise();
        csb0 = 1'b0; web0 = 1'b0; addr0 = AW'($urandom()); din0 = rand_word(); wmask0 = '1;
    endtask

    task automatic test_reset();
        logic exp_rdy;
        rst0 = 1'b1; drive_idle();
        tick();
        vectors++;
        if ({ready_rf, ready_wf, dout_rf, dout_wf} !== {2'b00, {(2*DW){1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_state ready=%b%b dout_rf=%h expected ready=00 dout=0", ready_rf, ready_wf, dout_rf);
        end
        tick();
        rst0 = 1'b0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            tick();
            exp_rdy = (k == DEPTH);
            vectors++;
            if ({ready_rf, ready_wf} !== {exp_rdy, exp_rdy}) begin
                miscompares++;
                $display("FAIL sweep_ready cycle=%0d got %b%b expected %b%b", k, ready_rf, ready_wf, exp_rdy, exp_rdy);
            end
        end
        for (int unsigned a = 0; a < DEPTH; a++) model[a] = '0;
        drive_read(AW'(5));
        tick();
        vectors++;
        if ({dout_rf, dout_wf} !== {model[5], model[5]}) begin
            miscompares++;
            $display("FAIL read_after_clear got %h / %h expected 0", dout_rf, dout_wf);
        end
    endtask

    task automatic test_full_write();
        logic [DW-1:0] d, old;
        d = {(DW/8){8'hA5}};
        old = model[3];
        drive_write(AW'(3), d, '1);
        tick();
        model[3] = merge(old, d, '1);
        vectors++;
        if ({dout_rf, dout_wf} !== {old, d}) begin
            miscompares++;
            $display("FAIL full_write_rdw got %h / %h expected %h / %h", dout_rf, dout_wf, old, d);
        end
        drive_read(AW'(3));
        tick();
        vectors++;
        if ({dout_rf, dout_wf} !== {d, d}) begin
            miscompares++;
            $display("FAIL full_write_read got %h / %h expected %h", dout_rf, dout_wf, d);
        end
    endtask

    task automatic test_partial_write();
        logic [DW-1:0] d, old, exp;
        d = rand_word(); d[7:0] = 8'h3C;
        old = {(DW/8){8'hA5}};
        exp = old; exp[WS-1:0] = d[WS-1:0];
        drive_write(AW'(3), d, NW'(1));
        tick();
        model[3] = merge(model[3], d, NW'(1));
        vectors++;
        if ({dout_rf, dout_wf} !== {old, exp}) begin
            miscompares++;
            $display("FAIL partial_rdw got %h / %h expected %h / %h", dout_rf, dout_wf, old, exp);
        end
        drive_read(AW'(3));
        tick();
        vectors++;
        if ({dout_rf, dout_wf} !== {exp, exp}) begin
            miscompares++;
            $display("FAIL partial_read got %h / %h expected %h", dout_rf, dout_wf, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [DW-1:0] d1, d2, w1, w2;
        logic [NW-1:0] m1, m2;
        a = AW'($urandom()); d1 = rand_word(); d2 = rand_word();
        m1 = NW'($urandom()); m2 = NW'($urandom());
        w1 = merge(model[a], d1, m1);
        w2 = merge(w1, d2, m2);
        drive_write(a, d1, m1);
        tick();
        drive_write(a, d2, m2);
        tick();
        vectors++;
        if ({dout_rf, dout_wf} !== {w1, w2}) begin
            miscompares++;
            $display("FAIL b2b_second_rdw got %h / %h expected %h / %h", dout_rf, dout_wf, w1, w2);
        end
        model[a] = w2;
        drive_read(a);
        tick();
        vectors++;
        if ({dout_rf, dout_wf} !== {w2, w2}) begin
            miscompares++;
            $display("FAIL b2b_read got %h / %h expected %h", dout_rf, dout_wf, w2);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [DW-1:0] d, old, nw;
        logic [NW-1:0] m;
        for (int unsigned n = 0; n < 300; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    a = AW'($urandom()); d = rand_word(); m = NW'($urandom());
                    old = model[a]; nw = merge(old, d, m);
                    drive_write(a, d, m);
                    tick();
                    model[a] = nw;
                    vectors++;
                    if ({dout_rf, dout_wf} !== {old, nw}) begin
                        miscompares++;
                        $display("FAIL rand_write op=%0d addr=%0d got %h / %h expected %h / %h", n, a, dout_rf, dout_wf, old, nw);
                    end
                end
                1: begin
                    a = AW'($urandom());
                    drive_read(a);
                    tick();
                    vectors++;
                    if ({dout_rf, dout_wf} !== {model[a], model[a]}) begin
                        miscompares++;
                        $display("FAIL rand_read op=%0d addr=%0d got %h / %h expected %h", n, a, dout_rf, dout_wf, model[a]);
                    end
                end
                default: begin
                    drive_idle();
                    tick();
                    vectors++;
                    if ({dout_rf, dout_wf} !== {model[cur_addr], model[cur_addr]}) begin
                        miscompares++;
                        $display("FAIL rand_idle op=%0d addr=%0d got %h / %h expected %h", n, cur_addr, dout_rf, dout_wf, model[cur_addr]);
                    end
                end
            endcase
        end
    endtask

`ifdef SRAM_PARITY_EN
    task automatic test_parity();
        logic [DW-1:0] d;
        d = 64'h1234_5678_9ABC_DEF0;
        drive_write(AW'(40), d, '1);
        tick();
        drive_read(AW'(40));
        tick();
        model[40] = d;
        vectors++;
        if ({dout_rf, perr_rf, perr_wf} !== {d, {(2*NW){1'b0}}}) begin
            miscompares++;
            $display("FAIL parity_clean dout=%h perr=%b/%b expected %h perr=0", dout_rf, perr_rf, perr_wf, d);
        end
        dut.flip_bit(AW'(40), 17);
        dut_wf.flip_bit(AW'(40), 17);
        #1;
        model[40][17] = ~model[40][17];
        vectors++;
        if ({dout_rf, perr_rf, perr_wf} !== {model[40], 4'b0010, 4'b0010}) begin
            miscompares++;
            $display("FAIL parity_flip dout=%h perr=%b/%b expected %h perr=0010", dout_rf, perr_rf, perr_wf, model[40]);
        end
    endtask
`endif

    task automatic test_mid_sweep_reset();
        logic exp_rdy;
        rst0 = 1'b1; drive_idle();
        tick(); tick();
        rst0 = 1'b0;
        for (int unsigned k = 1; k <= 7; k++) begin
            drive_clear_noise();
            tick();
            vectors++;
            if ({ready_rf, dout_rf} !== {1'b0, {DW{1'b0}}}) begin
                miscompares++;
                $display("FAIL early_sweep cycle=%0d ready=%b dout=%h expected 0/0", k, ready_rf, dout_rf);
            end
        end
        rst0 = 1'b1;
        #1;
        vectors++;
        if ({ready_rf, ready_wf, dout_rf} !== {2'b00, {DW{1'b0}}}) begin
            miscompares++;
            $display("FAIL mid_reset ready=%b%b dout=%h expected 00/0", ready_rf, ready_wf, dout_rf);
        end
        tick(); tick();
        rst0 = 1'b0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            drive_clear_noise();
            tick();
            exp_rdy = (k == DEPTH);
            vectors++;
            if ({ready_rf, ready_wf} !== {exp_rdy, exp_rdy}) begin
                miscompares++;
                $display("FAIL resweep_ready cycle=%0d got %b%b expected %b%b", k, ready_rf, ready_wf, exp_rdy, exp_rdy);
            end
        end
        for (int unsigned a = 0; a < DEPTH; a++) model[a] = '0;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            drive_read(AW'(a));
            tick();
            vectors++;
            if ({dout_rf, dout_wf} !== {model[a], model[a]}) begin
                miscompares++;
                $display("FAIL resweep_read addr=%0d got %h / %h expected 0", a, dout_rf, dout_wf);
            end
        end
    endtask

    initial begin
        rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1;
        wmask0 = '0; addr0 = '0; din0 = '0; cur_addr = '0;
        test_reset();
        test_full_write();
        test_partial_write();
        test_back_to_back();
        test_random();
`ifdef SRAM_PARITY_EN
        test_parity();
`endif
        test_mid_sweep_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
